// File: rtl/gelato_inst_ram.sv
// gelato_inst_ram: word-addressed instruction store answering (valid, addr) fetch
// requests with a fixed access latency, plus a loader write port.
//
// Handshake: a request is accepted on a rdy=1 edge while the responder is in IDLE or
// RESP and req_valid=1; the latched request always completes regardless of later
// changes on req_valid/req_addr. req_done is high for exactly the cycles spent in
// RESP and, because rdy=0 freezes the FSM, it stays high until one rdy=1 edge passes.
module gelato_inst_ram #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_done,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [1:0]            dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [IW-1:0]         w_rd_idx;
  logic                  w_rd_oor;
  logic [IW-1:0]         w_wr_idx;
  logic                  w_wr_oor;
  logic                  w_unused;

  // A new request can be taken from IDLE and, back-to-back, from RESP.
  assign w_accept     = ((r_state == S_IDLE) || (r_state == S_RESP)) && req_valid;
  // RESP is entered either when the wait countdown expires or directly on accept
  // when the latency is a single cycle.
  assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                        (w_accept && (LATENCY == 1));
  // With single-cycle latency the word is read on the accept edge itself, before the
  // address has been latched, so the live request address is used.
  assign w_rd_addr    = (r_state == S_WAIT) ? r_addr : req_addr;
  assign w_rd_idx     = w_rd_addr[IW+1:2];
  assign w_rd_oor     = |w_rd_addr[ADDR_WIDTH-1:IW+2];
  assign w_wr_idx     = wr_addr[IW+1:2];
  assign w_wr_oor     = |wr_addr[ADDR_WIDTH-1:IW+2];
  // Byte offsets within a word carry no information for a word store.
  assign w_unused     = ^{w_rd_addr[1:0], wr_addr[1:0]};

  // State register: reset wins, otherwise advance only on rdy edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (req_valid) begin
          w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: done is a pure decode of RESP; data/err come from response registers.
  always_comb begin
    req_done  = (r_state == S_RESP);
    req_data  = r_data;
    req_err   = r_err;
    dbg_state = r_state;
  end

  // Request datapath: latch address, run the countdown, capture the response word
  // (read-old with respect to a loader write on the same edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (rdy) begin
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= CW'(LATENCY - 2);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_enter_resp) begin
        r_err  <= w_rd_oor;
        r_data <= w_rd_oor ? '0 : r_mem[w_rd_idx];
      end
    end
  end

  // Loader write port: independent of rdy and reset; out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !w_wr_oor) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_gelato_inst_ram.sv
// Bench for gelato_inst_ram: two instances (latency 2 and latency 1) share all inputs
// and are compared every cycle against a timestamp-style reference model, with
// directed literal expectations for the key scenarios.
module tb_gelato_inst_ram;

  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        done2, err2, done1, err1;
  logic [31:0] data2, data1;
  logic [1:0]  dbg2, dbg1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gelato_inst_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .req_valid(req_valid), .req_addr(req_addr),
    .req_done(done2), .req_data(data2), .req_err(err2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg2)
  );

  gelato_inst_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .req_valid(req_valid), .req_addr(req_addr),
    .req_done(done1), .req_data(data1), .req_err(err1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg1)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance tracks how many rdy edges have elapsed since its request was
  // accepted; the response fires on the edge where that count reaches LATENCY.
  int          lat [2] = '{2, 1};
  logic [31:0] m_mem [DEPTH];
  bit          m_busy [2];
  int          m_edges [2];
  logic [31:0] m_addr [2];
  logic        m_done [2];
  logic [31:0] m_data [2];
  logic        m_err [2];

  always @(posedge clk) begin
    bit          fire;
    bit          was_free;
    logic [31:0] fa;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_data[i] = '0;
        m_err[i]  = 1'b0;
      end else if (rdy) begin
        fire     = 1'b0;
        fa       = '0;
        was_free = !m_busy[i];
        if (m_busy[i]) begin
          m_edges[i]++;
          if (m_edges[i] == lat[i]) begin
            fire      = 1'b1;
            fa        = m_addr[i];
            m_busy[i] = 1'b0;
          end
        end
        if (was_free && req_valid) begin
          m_addr[i]  = req_addr;
          m_edges[i] = 1;
          if (lat[i] == 1) begin
            fire = 1'b1;
            fa   = req_addr;
          end else begin
            m_busy[i] = 1'b1;
          end
        end
        m_done[i] = fire;
        if (fire) begin
          if (fa >= 32'(4 * DEPTH)) begin
            m_data[i] = '0;
            m_err[i]  = 1'b1;
          end else begin
            m_data[i] = m_mem[fa / 4];
            m_err[i]  = 1'b0;
          end
        end
      end
    end
    // Memory update after the reads so a same-edge write is not seen (read-old).
    if (wr_en && (wr_addr < 32'(4 * DEPTH))) m_mem[wr_addr / 4] = wr_data;
  end

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_done_l2", {31'b0, done2}, {31'b0, m_done[0]});
      check("model_data_l2", data2, m_data[0]);
      check("model_err_l2",  {31'b0, err2},  {31'b0, m_err[0]});
      check("model_done_l1", {31'b0, done1}, {31'b0, m_done[1]});
      check("model_data_l1", data1, m_data[1]);
      check("model_err_l1",  {31'b0, err1},  {31'b0, m_err[1]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; rdy = 1'b1; req_valid = 1'b0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    chk_en = 1'b1;

    // Preload every word so reads are always defined (writes work during reset).
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = 32'(i * 4);
      wr_data = $urandom;
      step();
    end
    wr_en = 1'b0;

    // 1 Reset with valid held high.
    req_valid = 1'b1; req_addr = 32'h14;
    step();
    check("rst_done_a", {31'b0, done2}, 32'd0);
    check("rst_data_a", data2, 32'd0);
    check("rst_err_a",  {31'b0, err2}, 32'd0);
    step();
    check("rst_done_b", {31'b0, done2}, 32'd0);
    check("rst_done_b1", {31'b0, done1}, 32'd0);
    rst_n = 1'b1; req_valid = 1'b0;
    check("rel_done_c0", {31'b0, done2}, 32'd0);
    step();
    check("rel_done_c1", {31'b0, done2}, 32'd0);

    // 2 Basic read and 3 back-to-back.
    load(32'h14, 32'hDEADBEEF);
    load(32'h18, 32'h12345678);
    req_valid = 1'b1; req_addr = 32'h14;
    step();
    check("basic_c1_done", {31'b0, done2}, 32'd0);
    check("l1_c1_done",    {31'b0, done1}, 32'd1);
    check("l1_c1_data",    data1, 32'hDEADBEEF);
    step();
    check("basic_c2_done", {31'b0, done2}, 32'd1);
    check("basic_c2_data", data2, 32'hDEADBEEF);
    check("basic_c2_err",  {31'b0, err2}, 32'd0);
    check("l1_c2_done",    {31'b0, done1}, 32'd1);
    req_addr = 32'h18;
    step();
    check("b2b_c3_done", {31'b0, done2}, 32'd0);
    check("l1_c3_done",  {31'b0, done1}, 32'd1);
    check("l1_c3_data",  data1, 32'h12345678);
    step();
    check("b2b_c4_done", {31'b0, done2}, 32'd1);
    check("b2b_c4_data", data2, 32'h12345678);
    req_valid = 1'b0;
    step();
    check("b2b_c5_done", {31'b0, done2}, 32'd0);

    // 4 Out of range, then misaligned.
    req_valid = 1'b1; req_addr = 32'h1000;
    step(); step();
    check("oor_done", {31'b0, done2}, 32'd1);
    check("oor_data", data2, 32'd0);
    check("oor_err",  {31'b0, err2}, 32'd1);
    req_addr = 32'h17;
    step(); step();
    check("mis_done", {31'b0, done2}, 32'd1);
    check("mis_data", data2, 32'hDEADBEEF);
    check("mis_err",  {31'b0, err2}, 32'd0);
    req_valid = 1'b0;
    step();

    // 5 Stall during WAIT, then stall in the done cycle.
    req_valid = 1'b1; req_addr = 32'h18;
    step();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_wait_done", {31'b0, done2}, 32'd0);
    end
    rdy = 1'b1;
    step();
    check("stall_late_done", {31'b0, done2}, 32'd1);
    check("stall_late_data", data2, 32'h12345678);
    req_valid = 1'b0; rdy = 1'b0;
    step();
    check("stall_hold_1", {31'b0, done2}, 32'd1);
    step();
    check("stall_hold_2", {31'b0, done2}, 32'd1);
    rdy = 1'b1;
    step();
    check("stall_release", {31'b0, done2}, 32'd0);

    // 6a Write to the latched word on the edge entering RESP.
    req_valid = 1'b1; req_addr = 32'h14;
    step();
    wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hCAFEF00D;
    step();
    wr_en = 1'b0;
    check("haz_old_done", {31'b0, done2}, 32'd1);
    check("haz_old_data", data2, 32'hDEADBEEF);
    step(); step();
    check("haz_new_done", {31'b0, done2}, 32'd1);
    check("haz_new_data", data2, 32'hCAFEF00D);
    req_valid = 1'b0;
    step();

    // 6b Reset pulse mid-WAIT drops the request.
    req_valid = 1'b1; req_addr = 32'h18;
    step();
    rst_n = 1'b0; req_valid = 1'b0;
    step();
    check("midrst_done", {31'b0, done2}, 32'd0);
    check("midrst_data", data2, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_nodone", {31'b0, done2}, 32'd0);
    end

    // Randomized phase, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 249) != 0);
      if (!req_valid || ($urandom_range(0, 3) == 0)) begin
        req_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) req_addr = $urandom;
        else                            req_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      end
      wr_en   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) wr_addr = $urandom;
      else                            wr_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      wr_data = $urandom;
      step();
    end
    req_valid = 1'b0; wr_en = 1'b0; rdy = 1'b1; rst_n = 1'b1;
    step(); step(); step();

    // ---------------- final report ----------------
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
